// File: rtl/nn_weight_loader.sv
// Packet-based weight loader: a SYNC_BYTE header, W payload bytes and an optional checksum are
// buffered, then replayed one write per cycle to the network core. The checksum stage is enabled by NN_WEIGHT_LOADER_CHECKSUM_EN.
module nn_weight_loader #(
  parameter int          BITS_PER_WORD      = 8,
  parameter logic [7:0]  SYNC_BYTE          = 8'hA5,
  parameter int          INPUT_VECTOR_SIZE  = 2,
  parameter int          HIDDEN_LAYER_SIZE  = 2,
  parameter int          OUTPUT_VECTOR_SIZE = 1,
  parameter int          BIAS_SIZE          = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            abort,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [7:0]                      s_data,
  output logic                            weights_en,
  output logic                            weights_layer_address,
  output logic [1:0]                      weights_n_address,
  output logic [1:0]                      weights_m_address,
  output logic signed [BITS_PER_WORD-1:0] weights_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int W = (INPUT_VECTOR_SIZE + BIAS_SIZE) * HIDDEN_LAYER_SIZE
                   + (HIDDEN_LAYER_SIZE + BIAS_SIZE) * OUTPUT_VECTOR_SIZE;
  localparam int IDX_W = $clog2(W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(W);
  localparam logic [1:0] N0_LAST = 2'(INPUT_VECTOR_SIZE + BIAS_SIZE - 1);
  localparam logic [1:0] M0_LAST = 2'(HIDDEN_LAYER_SIZE - 1);
  localparam logic [1:0] N1_LAST = 2'(HIDDEN_LAYER_SIZE + BIAS_SIZE - 1);
  localparam logic [1:0] M1_LAST = 2'(OUTPUT_VECTOR_SIZE - 1);

`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_e;
`endif

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               sum_q, sum_d;
  logic                     layer_q, layer_d;
  logic [1:0]               n_q, n_d;
  logic [1:0]               m_q, m_d;
  logic                     s_ready_q, s_ready_d;
  logic                     weights_en_q, weights_en_d;
  logic                     wl_addr_q, wl_addr_d;
  logic [1:0]               wn_addr_q, wn_addr_d;
  logic [1:0]               wm_addr_q, wm_addr_d;
  logic signed [BITS_PER_WORD-1:0] wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     buf_we;
  logic                     accept;
  logic [7:0]               buf_q [W];

  assign accept = s_valid && s_ready_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    layer_d      = layer_q;
    n_d          = n_q;
    m_d          = m_q;
    weights_en_d = 1'b0;
    wl_addr_d    = wl_addr_q;
    wn_addr_d    = wn_addr_q;
    wm_addr_d    = wm_addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    buf_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && s_data == SYNC_BYTE) begin
          state_d = LOAD;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          buf_we = 1'b1;
          sum_d  = sum_q + s_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            layer_d = 1'b0;
            n_d     = '0;
            m_d     = '0;
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          sum_d = '0;
          if (s_data == sum_q) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      COMMIT: begin
        if (idx_q == END_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          weights_en_d = 1'b1;
          wl_addr_d    = layer_q;
          wn_addr_d    = n_q;
          wm_addr_d    = m_q;
          wdata_d      = BITS_PER_WORD'($signed(buf_q[idx_q]));
          idx_d        = idx_q + 1'b1;
          // Walk m fastest, then n, then layer, matching the buffer order.
          if (!layer_q) begin
            if (m_q == M0_LAST) begin
              m_d = '0;
              if (n_q == N0_LAST) begin
                n_d     = '0;
                layer_d = 1'b1;
              end else begin
                n_d = n_q + 2'd1;
              end
            end else begin
              m_d = m_q + 2'd1;
            end
          end else if (m_q == M1_LAST) begin
            m_d = '0;
            if (n_q != N1_LAST) n_d = n_q + 2'd1;
          end else begin
            m_d = m_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      idx_d        = '0;
      sum_d        = '0;
      weights_en_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      buf_we       = 1'b0;
    end

    s_ready_d = (state_d != COMMIT);
    busy_d    = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sum_q        <= '0;
      layer_q      <= 1'b0;
      n_q          <= '0;
      m_q          <= '0;
      s_ready_q    <= 1'b0;
      weights_en_q <= 1'b0;
      wl_addr_q    <= 1'b0;
      wn_addr_q    <= '0;
      wm_addr_q    <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      layer_q      <= layer_d;
      n_q          <= n_d;
      m_q          <= m_d;
      s_ready_q    <= s_ready_d;
      weights_en_q <= weights_en_d;
      wl_addr_q    <= wl_addr_d;
      wn_addr_q    <= wn_addr_d;
      wm_addr_q    <= wm_addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the payload buffer is never read before being written, so it has no reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q] <= s_data;
  end

  assign s_ready               = s_ready_q;
  assign weights_en            = weights_en_q;
  assign weights_layer_address = wl_addr_q;
  assign weights_n_address     = wn_addr_q;
  assign weights_m_address     = wm_addr_q;
  assign weights_data          = wdata_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
  assign err                   = err_q;
`else
  assign err                   = 1'b0;
`endif

endmodule

// File: doc/nn_weight_loader.md
NN_WEIGHT_LOADER -- requirements
Module: nn_weight_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning): BITS_PER_WORD, 8, weight width.
REQ-002 SHALL have parameter SYNC_BYTE, 8'hA5, packet header value.
REQ-003 SHALL have parameters INPUT_VECTOR_SIZE 2, HIDDEN_LAYER_SIZE 2, OUTPUT_VECTOR_SIZE 1, BIAS_SIZE 1: network shape; W = (INPUT_VECTOR_SIZE+BIAS_SIZE)*HIDDEN_LAYER_SIZE + (HIDDEN_LAYER_SIZE+BIAS_SIZE)*OUTPUT_VECTOR_SIZE, 9 by default.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports listed as name, direction, width, meaning.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 abort  in  1  synchronous return to IDLE.
REQ-008 s_valid  in  1; s_ready  out  1; s_data  in  8: byte stream, transfer when s_valid and s_ready are both high.
REQ-009 weights_en  out  1; weights_layer_address  out  1; weights_n_address  out  2; weights_m_address  out  2; weights_data  out  BITS_PER_WORD signed: write port to the network core.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle pulse after the final weight write.
REQ-012 err  out  1  one-cycle pulse on checksum mismatch.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD, CHECK, COMMIT.
REQ-014 IDLE: s_ready=1; a byte equal to SYNC_BYTE moves the FSM to LOAD; any other byte is accepted and dropped.
REQ-015 LOAD: s_ready=1; accepts exactly W bytes into an internal W-entry buffer in arrival order; after byte W go to CHECK (or to COMMIT when the checksum is compiled out).
REQ-016 CHECK: s_ready=1; accepts one byte and compares it with the 8-bit sum, modulo 256, of the W buffered bytes; header excluded.
REQ-017 On a checksum match, the FSM SHALL go to COMMIT.
REQ-018 On a checksum mismatch, the FSM SHALL pulse err in the next cycle, issue no writes, and return to IDLE.
REQ-019 COMMIT: s_ready=0; emits one write per cycle, W consecutive cycles, weights_en=1 in each.
REQ-020 Write order: layer 0 for n=0..INPUT_VECTOR_SIZE+BIAS_SIZE-1, m=0..HIDDEN_LAYER_SIZE-1 with m fastest; then layer 1 for n=0..HIDDEN_LAYER_SIZE+BIAS_SIZE-1, m=0..OUTPUT_VECTOR_SIZE-1; buffer entries consumed in order.
REQ-021 Latency: if the last packet byte is accepted at edge T, the first weights_en is high in the cycle after T and the last is high in cycle T+W; done pulses in cycle T+W+1, together with return to IDLE.
REQ-022 All outputs SHALL be registered; address and data outputs SHALL hold their last value when weights_en=0.
REQ-023 abort SHALL have priority over every other event: in the next cycle state=IDLE, buffer index cleared, weights_en=0, and no done or err pulse, including mid-COMMIT.
REQ-024 s_valid low in LOAD or CHECK SHALL stall without timeout; gaps between bytes are legal.
REQ-025 SYNC_BYTE values inside LOAD or CHECK SHALL be treated as ordinary data.

Reset
REQ-026 reset_n low SHALL force asynchronously: state=IDLE, buffer index 0, running sum 0, s_ready=0, weights_en=0, all address and data outputs 0, busy=0, done=0, err=0.
REQ-027 s_ready SHALL rise in the first cycle after reset_n deasserts; buffer contents need no reset.
REQ-028 Reset during COMMIT SHALL abandon the remaining writes.

Configuration
REQ-029 SHALL use macro NN_WEIGHT_LOADER_CHECKSUM_EN: when defined, the CHECK state and err are active.
REQ-030 When NN_WEIGHT_LOADER_CHECKSUM_EN is undefined, LOAD goes directly to COMMIT after byte W, err is tied to 0, and there is no CHECK state. The REQ-021 latency is measured from byte W.

Verification
REQ-031 Reset, then A5, 01 02 03 04 05 06 07 08 09, checksum 2D -> 9 writes: (0,0,0)=01 ... (0,2,1)=06, (1,0,0)=07, (1,1,0)=08, (1,2,0)=09; done one cycle after the last write.
REQ-032 Same packet with checksum 2C -> err pulse, zero weights_en cycles, FSM back in IDLE.
REQ-033 Bytes 00 FF, then A5 and a valid packet -> leading bytes dropped; writes identical to REQ-031.
REQ-034 Valid packet with s_valid low for 3 cycles between every byte, and bytes A5 inside the payload -> correct writes; weight value A5 is written.
REQ-035 abort asserted on the 4th COMMIT cycle -> exactly 3 writes, no done pulse, s_ready=1 in the next cycle; a following valid packet commits fully.
REQ-036 reset_n pulsed low mid-LOAD -> all outputs 0 immediately; a fresh packet is then handled correctly.
